// File: rtl/flash_read_ctrl.sv
// SPI mode-0 master: one READ DATA (0x03) transaction per key_flag.
// It returns RD_NUM bytes, each as a parallel byte with a one-cycle po_flag strobe.
module flash_read_ctrl #(
    parameter logic [23:0] RD_ADDR = 24'h00_00_00,
    parameter logic [15:0] RD_NUM  = 16'd256
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       key_flag,
    input  logic       miso,
    output logic       sck,
    output logic       cs_n,
    output logic       mosi,
    output logic [7:0] po_data,
    output logic       po_flag,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE,
        CS_SETUP,
        SEND,
        READ,
        CS_HOLD
    } state_t;

    localparam logic [31:0] CMD_ADDR  = {8'h03, RD_ADDR};
    // Wraps to 16'hFFFF when RD_NUM is 0, but READ is never entered in that case
    localparam logic [15:0] LAST_BYTE = RD_NUM - 16'd1;

    state_t      state;
    state_t      state_next;
    logic [1:0]  cnt_clk;
    logic [2:0]  cnt_bit;
    logic [15:0] cnt_byte;
    logic [6:0]  shift_reg;
    logic        bit_end;
    logic        byte_end;
    logic        send_done;
    logic        read_done;
    logic        shifting;

    assign shifting  = (state == SEND) || (state == READ);
    assign bit_end   = (cnt_clk == 2'd3);
    assign byte_end  = bit_end && (cnt_bit == 3'd7);
    assign send_done = (state == SEND) && byte_end && (cnt_byte == 16'd3);
    assign read_done = (state == READ) && byte_end && (cnt_byte == LAST_BYTE);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (key_flag) state_next = CS_SETUP;
            CS_SETUP: if (bit_end) state_next = SEND;
            SEND:     if (send_done) state_next = (RD_NUM == 16'd0) ? CS_HOLD : READ;
            READ:     if (read_done) state_next = CS_HOLD;
            CS_HOLD:  if (bit_end) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // cnt_clk also times the 4-cycle CS_SETUP and CS_HOLD windows
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_clk  <= 2'd0;
            cnt_bit  <= 3'd0;
            cnt_byte <= 16'd0;
        end else if (state == IDLE) begin
            cnt_clk  <= 2'd0;
            cnt_bit  <= 3'd0;
            cnt_byte <= 16'd0;
        end else begin
            cnt_clk <= cnt_clk + 2'd1;
            if (shifting && bit_end) begin
                cnt_bit <= cnt_bit + 3'd1;
            end
            if (send_done || read_done) begin
                cnt_byte <= 16'd0;
            end else if (shifting && byte_end) begin
                cnt_byte <= cnt_byte + 16'd1;
            end
        end
    end

    // miso is sampled mid sck-high; the eighth sample completes the byte
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            shift_reg <= 7'd0;
            po_data   <= 8'h00;
            po_flag   <= 1'b0;
        end else begin
            po_flag <= 1'b0;
            if ((state == READ) && (cnt_clk == 2'd2)) begin
                shift_reg <= {shift_reg[5:0], miso};
                if (cnt_bit == 3'd7) begin
                    po_data <= {shift_reg, miso};
                    po_flag <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        cs_n = (state == IDLE);
        busy = (state != IDLE);
        sck  = 1'b0;
        mosi = 1'b0;
        if (shifting) begin
            sck = cnt_clk[1];
        end
        if (state == SEND) begin
            mosi = CMD_ADDR[5'd31 - {cnt_byte[1:0], cnt_bit}];
        end
    end

endmodule

// File: tb/tb_flash_read_ctrl.sv
// Bench for flash_read_ctrl: four parameterisations share one clock and a flash model.
// Each instance is checked cycle by cycle against a timing model built from transaction arithmetic.
`timescale 1ns/1ps
module tb_flash_read_ctrl;

    localparam int NI = 4;
    localparam logic [23:0] ADDR1 = 24'h12_34_56;
    localparam logic [23:0] ADDR2 = 24'h7E_81_00;
    localparam logic [23:0] ADDR3 = 24'hA5_0F_C3;

    typedef struct packed {
        logic cs_n;
        logic busy;
        logic sck;
        logic mosi;
        logic flag;
    } pins_t;

    localparam pins_t IDLE_PINS = 5'b10000;

    logic          sys_clk = 1'b0;
    logic          sys_rst_n;
    logic [NI-1:0] key_flag;
    logic [NI-1:0] miso;
    logic [NI-1:0] sck;
    logic [NI-1:0] cs_n;
    logic [NI-1:0] mosi;
    logic [NI-1:0] po_flag;
    logic [NI-1:0] busy;
    logic [7:0]    po_data [NI];

    logic [7:0]    flash_mem [NI][256];
    logic [7:0]    exp_data [NI];
    int            rise_cnt [NI];
    logic [NI-1:0] prev_sck;
    logic [31:0]   mosi_cap [NI];
    int            fm_idx;
    int            n_tests = 0;
    int            n_fail = 0;

    always #10 sys_clk = ~sys_clk;

    flash_read_ctrl #(.RD_ADDR(24'h00_00_00), .RD_NUM(16'd256)) dut0 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .key_flag(key_flag[0]), .miso(miso[0]),
        .sck(sck[0]), .cs_n(cs_n[0]), .mosi(mosi[0]), .po_data(po_data[0]),
        .po_flag(po_flag[0]), .busy(busy[0]));

    flash_read_ctrl #(.RD_ADDR(ADDR1), .RD_NUM(16'd2)) dut1 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .key_flag(key_flag[1]), .miso(miso[1]),
        .sck(sck[1]), .cs_n(cs_n[1]), .mosi(mosi[1]), .po_data(po_data[1]),
        .po_flag(po_flag[1]), .busy(busy[1]));

    flash_read_ctrl #(.RD_ADDR(ADDR2), .RD_NUM(16'd0)) dut2 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .key_flag(key_flag[2]), .miso(miso[2]),
        .sck(sck[2]), .cs_n(cs_n[2]), .mosi(mosi[2]), .po_data(po_data[2]),
        .po_flag(po_flag[2]), .busy(busy[2]));

    flash_read_ctrl #(.RD_ADDR(ADDR3), .RD_NUM(16'd4)) dut3 (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .key_flag(key_flag[3]), .miso(miso[3]),
        .sck(sck[3]), .cs_n(cs_n[3]), .mosi(mosi[3]), .po_data(po_data[3]),
        .po_flag(po_flag[3]), .busy(busy[3]));

    // Flash model: captures mosi on sck rise, shifts out memory bytes MSB first on sck fall
    always @(negedge sys_clk) begin
        for (int g = 0; g < NI; g++) begin
            if (!sys_rst_n || cs_n[g]) begin
                rise_cnt[g] = 0;
                prev_sck[g] = 1'b0;
                miso[g]     = 1'b0;
            end else begin
                if (sck[g] && !prev_sck[g]) begin
                    if (rise_cnt[g] < 32) mosi_cap[g] = {mosi_cap[g][30:0], mosi[g]};
                    rise_cnt[g] = rise_cnt[g] + 1;
                end else if (!sck[g] && prev_sck[g] && rise_cnt[g] >= 32) begin
                    fm_idx  = rise_cnt[g] - 32;
                    miso[g] = flash_mem[g][(fm_idx / 8) % 256][7 - (fm_idx % 8)];
                end
                prev_sck[g] = sck[g];
            end
        end
    end

    function automatic int num_of(input int g);
        case (g)
            0:       return 256;
            1:       return 2;
            2:       return 0;
            default: return 4;
        endcase
    endfunction

    function automatic logic [23:0] addr_of(input int g);
        case (g)
            0:       return 24'h00_00_00;
            1:       return ADDR1;
            2:       return ADDR2;
            default: return ADDR3;
        endcase
    endfunction

    // Expected pins in cycle k after the trigger edge (cycle 0)
    function automatic pins_t model_at(input int g, input int k);
        pins_t       p;
        int          n_bytes;
        int          n;
        logic [31:0] cmd;
        n_bytes = num_of(g);
        cmd     = {8'h03, addr_of(g)};
        p       = IDLE_PINS;
        if (k >= 1 && k <= 136 + 32 * n_bytes) begin
            p.cs_n = 1'b0;
            p.busy = 1'b1;
        end
        if (k >= 5 && k <= 132 + 32 * n_bytes) begin
            n     = (k - 5) / 4;
            p.sck = ((k - 5) % 4) >= 2;
            if (n < 32) p.mosi = cmd[31 - n];
        end
        if (k >= 164 && ((k - 164) % 32) == 0 && ((k - 164) / 32) < n_bytes) p.flag = 1'b1;
        return p;
    endfunction

    task automatic start_txn(input int g, input int idle);
        repeat (idle) @(negedge sys_clk);
        key_flag[g] = 1'b1;
        @(negedge sys_clk);
        key_flag[g] = 1'b0;
    endtask

    task automatic test_reset();
        pins_t got;
        int    flags;
        sys_rst_n = 1'b0;
        repeat (3) @(negedge sys_clk);
        for (int g = 0; g < NI; g++) begin
            got = {cs_n[g], busy[g], sck[g], mosi[g], po_flag[g]};
            n_tests += 2;
            if (got !== IDLE_PINS) begin
                n_fail++;
                $display("[TB] FAIL reset_pins inst %0d: got %b expected %b", g, got, IDLE_PINS);
            end
            if (po_data[g] !== 8'h00) begin
                n_fail++;
                $display("[TB] FAIL reset_po_data inst %0d: got %h expected 00", g, po_data[g]);
            end
        end
        sys_rst_n = 1'b1;
        flags = 0;
        repeat (1000) begin
            @(negedge sys_clk);
            for (int g = 0; g < NI; g++) begin
                got = {cs_n[g], busy[g], sck[g], mosi[g], po_flag[g]};
                if (po_flag[g]) flags++;
                n_tests++;
                if (got !== IDLE_PINS) begin
                    n_fail++;
                    $display("[TB] FAIL idle_pins inst %0d: got %b expected %b", g, got, IDLE_PINS);
                end
            end
        end
        n_tests++;
        if (flags != 0) begin
            n_fail++;
            $display("[TB] FAIL idle_flag_count: got %0d expected 0", flags);
        end
    endtask

    task automatic test_default_read(input bit rand_data);
        pins_t e;
        pins_t got;
        int    flags;
        for (int i = 0; i < 256; i++) flash_mem[0][i] = rand_data ? 8'($urandom) : 8'(i);
        flags = 0;
        start_txn(0, $urandom_range(0, 7));
        for (int k = 1; k <= 8340; k++) begin
            e   = model_at(0, k);
            got = {cs_n[0], busy[0], sck[0], mosi[0], po_flag[0]};
            if (e.flag) exp_data[0] = flash_mem[0][(k - 164) / 32];
            if (po_flag[0]) flags++;
            n_tests += 2;
            if (got !== e) begin
                n_fail++;
                $display("[TB] FAIL default_pins cycle %0d: got %b expected %b", k, got, e);
            end
            if (po_data[0] !== exp_data[0]) begin
                n_fail++;
                $display("[TB] FAIL default_po_data cycle %0d: got %h expected %h", k, po_data[0], exp_data[0]);
            end
            @(negedge sys_clk);
        end
        n_tests += 2;
        if (flags != 256) begin
            n_fail++;
            $display("[TB] FAIL default_flag_count: got %0d expected 256", flags);
        end
        if (mosi_cap[0] !== 32'h0300_0000) begin
            n_fail++;
            $display("[TB] FAIL default_cmd_addr: got %h expected 03000000", mosi_cap[0]);
        end
    endtask

    // Instance 1 reads two bytes of all-ones; instance 2 reads none
    task automatic test_short_reads();
        pins_t e;
        pins_t got;
        int    flags;
        int    last;
        for (int g = 1; g <= 2; g++) begin
            for (int i = 0; i < 256; i++) flash_mem[g][i] = (g == 1) ? 8'hFF : 8'($urandom);
            flags = 0;
            last  = 140 + 32 * num_of(g);
            start_txn(g, $urandom_range(0, 5));
            for (int k = 1; k <= last; k++) begin
                e   = model_at(g, k);
                got = {cs_n[g], busy[g], sck[g], mosi[g], po_flag[g]};
                if (e.flag) exp_data[g] = flash_mem[g][(k - 164) / 32];
                if (po_flag[g]) flags++;
                n_tests += 2;
                if (got !== e) begin
                    n_fail++;
                    $display("[TB] FAIL short_pins inst %0d cycle %0d: got %b expected %b", g, k, got, e);
                end
                if (po_data[g] !== exp_data[g]) begin
                    n_fail++;
                    $display("[TB] FAIL short_po_data inst %0d cycle %0d: got %h expected %h", g, k, po_data[g], exp_data[g]);
                end
                @(negedge sys_clk);
            end
            n_tests += 2;
            if (flags != num_of(g)) begin
                n_fail++;
                $display("[TB] FAIL short_flag_count inst %0d: got %0d expected %0d", g, flags, num_of(g));
            end
            if (mosi_cap[g] !== {8'h03, addr_of(g)}) begin
                n_fail++;
                $display("[TB] FAIL short_cmd_addr inst %0d: got %h expected %h", g, mosi_cap[g], {8'h03, addr_of(g)});
            end
        end
    endtask

    // Extra triggers while busy and in the last CS_HOLD cycle, then an immediate re-trigger
    task automatic test_ignored_triggers();
        pins_t e;
        pins_t got;
        int    flags;
        int    rk;
        localparam int HOLD_END = 264;
        for (int t = 0; t < 2; t++) begin
            for (int i = 0; i < 256; i++) flash_mem[3][i] = 8'($urandom);
            flags = 0;
            rk    = $urandom_range(2, HOLD_END);
            start_txn(3, (t == 0) ? $urandom_range(0, 5) : 0);
            for (int k = 1; k <= HOLD_END + 4; k++) begin
                e   = model_at(3, k);
                got = {cs_n[3], busy[3], sck[3], mosi[3], po_flag[3]};
                if (e.flag) exp_data[3] = flash_mem[3][(k - 164) / 32];
                if (po_flag[3]) flags++;
                n_tests += 2;
                if (got !== e) begin
                    n_fail++;
                    $display("[TB] FAIL ignore_pins txn %0d cycle %0d: got %b expected %b", t, k, got, e);
                end
                if (po_data[3] !== exp_data[3]) begin
                    n_fail++;
                    $display("[TB] FAIL ignore_po_data txn %0d cycle %0d: got %h expected %h", t, k, po_data[3], exp_data[3]);
                end
                key_flag[3] = (k == 50) || (k == 200) || (k == HOLD_END) || (k == rk);
                @(negedge sys_clk);
            end
            key_flag[3] = 1'b0;
            n_tests += 2;
            if (flags != 4) begin
                n_fail++;
                $display("[TB] FAIL ignore_flag_count txn %0d: got %0d expected 4", t, flags);
            end
            if (mosi_cap[3] !== {8'h03, ADDR3}) begin
                n_fail++;
                $display("[TB] FAIL ignore_cmd_addr txn %0d: got %h expected %h", t, mosi_cap[3], {8'h03, ADDR3});
            end
        end
    endtask

    task automatic test_reset_mid();
        pins_t e;
        pins_t got;
        for (int i = 0; i < 256; i++) flash_mem[0][i] = 8'($urandom);
        start_txn(0, $urandom_range(0, 5));
        for (int k = 1; k < 180; k++) begin
            e   = model_at(0, k);
            got = {cs_n[0], busy[0], sck[0], mosi[0], po_flag[0]};
            if (e.flag) exp_data[0] = flash_mem[0][(k - 164) / 32];
            n_tests += 2;
            if (got !== e) begin
                n_fail++;
                $display("[TB] FAIL midrst_pins cycle %0d: got %b expected %b", k, got, e);
            end
            if (po_data[0] !== exp_data[0]) begin
                n_fail++;
                $display("[TB] FAIL midrst_po_data cycle %0d: got %h expected %h", k, po_data[0], exp_data[0]);
            end
            @(negedge sys_clk);
        end
        sys_rst_n = 1'b0;
        #1;
        got = {cs_n[0], busy[0], sck[0], mosi[0], po_flag[0]};
        n_tests += 2;
        if (got !== IDLE_PINS) begin
            n_fail++;
            $display("[TB] FAIL midrst_async_pins: got %b expected %b", got, IDLE_PINS);
        end
        if (po_data[0] !== 8'h00) begin
            n_fail++;
            $display("[TB] FAIL midrst_async_po_data: got %h expected 00", po_data[0]);
        end
        for (int g = 0; g < NI; g++) exp_data[g] = 8'h00;
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        @(negedge sys_clk);
        test_default_read(1'b1);
    endtask

    initial begin
        sys_rst_n = 1'b0;
        key_flag  = '0;
        for (int g = 0; g < NI; g++) exp_data[g] = 8'h00;
        test_reset();
        test_default_read(1'b0);
        test_short_reads();
        test_ignored_triggers();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
